// File: rtl/fir_reg_bank.sv
// FIR register bank: coefficients, NSAMP, control FSM and read pipeline.
// Optional level interrupt enabled by defining FIR_REG_BANK_IRQ_EN.
module fir_reg_bank #(
  parameter int N_COEF = 32,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [5:0]        p_address,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_wr,
  output logic [DATA_W-1:0] p_data_back,
  input  logic [4:0]        coef_idx,
  output logic [DATA_W-1:0] coef_out,
  output logic              start,
  output logic [DATA_W-1:0] num_samples,
  input  logic              core_done,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [5:0] NC     = 6'(N_COEF);
  localparam logic [5:0] A_CTRL = 6'h20;
  localparam logic [5:0] A_DONE = 6'h21;
  localparam logic [5:0] A_PRAC = 6'h22;
  localparam logic [5:0] A_NSMP = 6'h23;
  localparam logic [5:0] A_ERR  = 6'h24;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] coef [N_COEF];
  logic [DATA_W-1:0] nsamp_q;
  logic [ERR_W-1:0]  err_q;
  logic              irq_en_q;
  logic              start_q;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_out_q;

  logic is_coef;
  logic is_ctrl;
  logic is_done;
  logic is_prac;
  logic is_nsmp;
  logic is_err;
  logic wr_coef;
  logic wr_ctrl;
  logic wr_nsmp;
  logic wr_err;
  logic in_run;
  logic go_req;
  logic go_ok;
  logic blocked;

  assign is_coef = p_address < NC;
  assign is_ctrl = p_address == A_CTRL;
  assign is_done = p_address == A_DONE;
  assign is_prac = p_address == A_PRAC;
  assign is_nsmp = p_address == A_NSMP;
  assign is_err  = p_address == A_ERR;

  assign wr_coef = p_wr & is_coef;
  assign wr_ctrl = p_wr & is_ctrl;
  assign wr_nsmp = p_wr & is_nsmp;
  assign wr_err  = p_wr & is_err;

  assign in_run  = state_q == ST_RUN;
  assign go_req  = wr_ctrl & p_data[0];
  assign go_ok   = go_req & ~in_run;
  // a START seen in RUN is refused but still counted, even alongside core_done
  assign blocked = in_run & (wr_coef | wr_nsmp | go_req);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (go_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      start_q <= 1'b0;
    end else begin
      start_q <= go_ok;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < N_COEF; i++) begin
        coef[i] <= '0;
      end
    end else if (wr_coef && !in_run) begin
      coef[p_address[4:0]] <= p_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      nsamp_q <= '0;
    end else if (wr_nsmp && !in_run) begin
      nsamp_q <= p_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_q <= '0;
    end else if (wr_err) begin
      err_q <= '0;
    end else if (blocked && err_q != ERR_MAX) begin
      err_q <= err_q + 1'b1;
    end
  end

`ifdef FIR_REG_BANK_IRQ_EN
  logic irq_en_d;
  logic irq_q;

  assign irq_en_d = wr_ctrl ? p_data[1] : irq_en_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_d & (state_q == ST_DONE) & ~go_ok;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      is_coef: rd_mux = coef[p_address[4:0]];
      is_ctrl: rd_mux[1] = irq_en_q;
      is_done: rd_mux[0] = state_q == ST_DONE;
      is_prac: rd_mux[0] = state_q == ST_RUN;
      is_nsmp: rd_mux = nsamp_q;
      is_err:  rd_mux[ERR_W-1:0] = err_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rd_q     <= '0;
      rd_out_q <= '0;
    end else begin
      rd_q     <= rd_mux;
      rd_out_q <= rd_q;
    end
  end

  always_comb begin
    coef_out = '0;
    if ({1'b0, coef_idx} < NC) coef_out = coef[coef_idx];
  end

  assign p_data_back = rd_out_q;
  assign start       = start_q;
  assign num_samples = nsamp_q;

endmodule

// File: tb/tb_fir_reg_bank.sv
// Scoreboard bench for fir_reg_bank.
// Covers default build and FIR_REG_BANK_IRQ_EN build.
module tb_fir_reg_bank;

  logic        PCLK;
  logic        PRESETn;
  logic [5:0]  p_address;
  logic [15:0] p_data;
  logic        p_wr;
  logic [15:0] p_data_back;
  logic [4:0]  coef_idx;
  logic [15:0] coef_out;
  logic        start;
  logic [15:0] num_samples;
  logic        core_done;
  logic        irq;

  fir_reg_bank dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .p_address   (p_address),
    .p_data      (p_data),
    .p_wr        (p_wr),
    .p_data_back (p_data_back),
    .coef_idx    (coef_idx),
    .coef_out    (coef_out),
    .start       (start),
    .num_samples (num_samples),
    .core_done   (core_done),
    .irq         (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk;
  int n_fail;

  logic [15:0] exp_q [$];
  logic [15:0] last_exp;

  logic [15:0] m_coef [32];
  logic [15:0] m_nsamp;
  int          m_err;
  int          m_st;
  bit          m_ie;
  bit          m_start;

`ifdef FIR_REG_BANK_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic m_reset();
    foreach (m_coef[i]) m_coef[i] = '0;
    m_nsamp = '0;
    m_err   = 0;
    m_st    = 0;
    m_ie    = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic bump();
    if (m_err < 255) m_err++;
  endtask

  function automatic logic [15:0] mread(input logic [5:0] a);
    logic [15:0] v;
    v = '0;
    if (a < 6'd32) v = m_coef[a[4:0]];
    else if (a == 6'h20) v[1] = HAS_IRQ & m_ie;
    else if (a == 6'h21) v[0] = (m_st == 2);
    else if (a == 6'h22) v[0] = (m_st == 1);
    else if (a == 6'h23) v = m_nsamp;
    else if (a == 6'h24) v = 16'(m_err);
    return v;
  endfunction

  task automatic wr(input logic [5:0] a,
                    input logic [15:0] d,
                    input bit cd);
    bit run;
    run = (m_st == 1);
    m_start = 1'b0;
    if (a < 6'd32) begin
      if (run) bump();
      else m_coef[a[4:0]] = d;
    end else if (a == 6'h20) begin
      m_ie = d[1];
      if (d[0]) begin
        if (run) bump();
        else begin
          m_st = 1;
          m_start = 1'b1;
        end
      end
    end else if (a == 6'h23) begin
      if (run) bump();
      else m_nsamp = d;
    end else if (a == 6'h24) begin
      m_err = 0;
    end
    if (run && cd) m_st = 2;
    p_address = a;
    p_data    = d;
    p_wr      = 1'b1;
    core_done = cd;
    tick();
    p_wr      = 1'b0;
    core_done = 1'b0;
    chk("start", {31'b0, start}, {31'b0, m_start});
  endtask

  task automatic done_pulse();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    if (m_st == 1) m_st = 2;
  endtask

  task automatic rd(input logic [5:0] a,
                    input string tag,
                    input bit stale);
    logic [15:0] e;
    e = mread(a);
    exp_q.push_back(e);
    p_address = a;
    tick();
    if (stale) chk("rd_lat", {16'b0, p_data_back}, {16'b0, last_exp});
    tick();
    chk(tag, {16'b0, p_data_back}, {16'b0, exp_q.pop_front()});
    last_exp = e;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    last_exp  = '0;
    PRESETn   = 1'b0;
    p_address = '0;
    p_data    = '0;
    p_wr      = 1'b0;
    coef_idx  = '0;
    core_done = 1'b0;
    m_reset();
    repeat (2) tick();
    chk("rst_pdb", {16'b0, p_data_back}, 32'h0);
    chk("rst_start", {31'b0, start}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    PRESETn = 1'b1;
    tick();

    for (int a = 0; a <= 'h24; a++) begin
      rd(6'(a), "rst_rd", 1'b0);
      repeat (4) tick();
    end
    chk("rst_irq2", {31'b0, irq}, 32'h0);

    wr(6'd5, 16'hBEEF, 1'b0);
    wr(6'h23, 16'h0040, 1'b0);
    wr(6'h30, 16'hFFFF, 1'b0);
    rd(6'd5, "coef5", 1'b0);
    rd(6'h23, "nsamp", 1'b1);
    rd(6'h30, "unmapped", 1'b0);
    coef_idx = 5'd5;
    #1;
    chk("coef_out", {16'b0, coef_out}, 32'hBEEF);
    chk("num_samples", {16'b0, num_samples}, 32'h0040);

    wr(6'h20, 16'h0003, 1'b0);
    tick();
    chk("start_1cyc", {31'b0, start}, 32'h0);
    rd(6'h22, "prac_run", 1'b0);
    rd(6'h21, "done_run", 1'b0);
    done_pulse();
    chk("irq_entry", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'b0, irq}, {31'b0, HAS_IRQ});
    rd(6'h21, "done_done", 1'b0);
    rd(6'h22, "prac_done", 1'b0);
    rd(6'h20, "ctrl_rd", 1'b0);

    wr(6'h20, 16'h0001, 1'b0);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    wr(6'd0, 16'h1234, 1'b0);
    wr(6'h20, 16'h0001, 1'b0);
    rd(6'd0, "coef0_blk", 1'b0);
    rd(6'h24, "err2", 1'b0);
    wr(6'h24, 16'h0000, 1'b0);
    rd(6'h24, "err_clr", 1'b0);

    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 1) wr(6'h23, 16'(i), 1'b0);
      else wr(6'(i % 32), 16'(i), 1'b0);
    end
    rd(6'h24, "err_sat", 1'b0);
    wr(6'h20, 16'h0001, 1'b1);
    rd(6'h21, "done_sim", 1'b0);
    rd(6'h24, "err_sim", 1'b0);
    rd(6'h23, "nsamp_keep", 1'b0);

    wr(6'h20, 16'h0001, 1'b0);
    done_pulse();
    wr(6'h20, 16'h0001, 1'b0);
    PRESETn = 1'b0;
    #1;
    m_reset();
    chk("arst_start", {31'b0, start}, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_nsamp", {16'b0, num_samples}, 32'h0);
    tick();
    PRESETn = 1'b1;
    tick();
    rd(6'h21, "post_done", 1'b0);
    rd(6'h22, "post_prac", 1'b0);
    rd(6'd5, "post_coef", 1'b0);
    rd(6'h23, "post_nsamp", 1'b0);
    coef_idx = 5'd5;
    #1;
    chk("post_coef_out", {16'b0, coef_out}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_reg_bank.md
Name: fir_reg_bank

Overview:
Register bank and control FSM directly downstream of the APB bridge in the FIR peripheral. It consumes the bridge's internal write port (p_address/p_data/p_wr) and returns read data on p_data_back within the bridge's fixed read wait window. It holds the FIR coefficients and sample count, and drives the FIR core's start/coefficient interface. It tracks run state and exposes it as the DONE (0x21) and PRACUJE (0x22) read-only registers.

Parameters:
N_COEF, 32, number of coefficient registers at addresses 0x00..N_COEF-1; must be ≤32.
DATA_W, 16, width of every register and of p_data/p_data_back.
ERR_W, 8, width of the blocked-write error counter.

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
p_address  in  6  register address from the bridge; held stable during a read
p_data  in  DATA_W  write data from the bridge
p_wr  in  1  single-cycle write strobe
p_data_back  out  DATA_W  read data for p_address; registered, 2-cycle latency
coef_idx  in  5  coefficient index requested by the FIR core
coef_out  out  DATA_W  COEF[coef_idx], combinational; 0 if coef_idx ≥ N_COEF
start  out  1  single-cycle pulse that starts the FIR core
num_samples  out  DATA_W  current NSAMP register value
core_done  in  1  single-cycle pulse from the core at end of a run
irq  out  1  level interrupt (optional feature only)

Behaviour:
- Clock and reset: PCLK; reset PRESETn, asynchronous, active-low.
- Reset values: COEF[*]=0, NSAMP=0, IRQ_EN=0, ERRCNT=0, state=IDLE, start=0, p_data_back=0, irq=0.
- Register map:
  - 0x00..N_COEF-1 COEF[i], RW.
  - 0x20 CTRL: bit0 START, write-1 action, reads 0; bit1 IRQ_EN, RW.
  - 0x21 DONE, RO: bit0 = (state==DONE).
  - 0x22 PRACUJE, RO: bit0 = (state==RUN).
  - 0x23 NSAMP, RW.
  - 0x24 ERRCNT, RO; any write clears it to 0.
  - Unmapped addresses read 0; writes to them are ignored.
  - Writes to 0x21/0x22 are ignored (the bridge already filters them).
- Writes: take effect on the PCLK edge where p_wr=1, using p_address/p_data from the same cycle.
- Read path:
  - Stage 1 registers mux(p_address); stage 2 registers that value onto p_data_back.
  - Data for a new address is valid 2 cycles after p_address changes, which is within the bridge's 6-cycle wait.
  - Reads have no side effects.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN: on a CTRL write with bit0=1. start=1 on the following cycle for exactly 1 cycle; DONE reads 0 from that cycle on.
  - RUN → DONE: on core_done=1.
  - core_done in IDLE or DONE is ignored.
- Blocked writes, state RUN: writes to COEF[*], to NSAMP, or a CTRL write with bit0=1 are not applied. Each one increments ERRCNT.
  - A CTRL write with bit0=0 still updates IRQ_EN in RUN.
  - A CTRL write with bit0=1 in RUN still applies IRQ_EN and counts as a blocked start.
- ERRCNT saturates at 2^ERR_W-1, with no wrap-around.
  - If a clear write and a blocked write occur in the same cycle, the clear wins.
- Simultaneous events, state RUN: core_done and a CTRL START write in the same cycle → the transition to DONE wins, no start pulse, ERRCNT++.
  - A START written in the cycle after entering DONE is accepted normally.
- Reset mid-run: state returns to IDLE and start/irq deassert immediately (asynchronous). The core is responsible for its own reset.

Optional Feature:
Macro FIR_REG_BANK_IRQ_EN.
- Defined: irq = IRQ_EN & (state==DONE), registered, so it rises 1 cycle after entering DONE. It clears on the cycle a START is accepted or when IRQ_EN is written to 0.
- Not defined: irq tied to 0; CTRL bit1 is not stored and reads 0.

Test Plan:
1. Reset, then read 0x00..0x24 (hold each address 6 cycles) → p_data_back=0 everywhere; irq=0, start=0.
2. Write COEF[5]=0xBEEF and NSAMP=0x0040, read both back → p_data_back=0xBEEF and 0x0040 exactly 2 cycles after each address change. Set coef_idx=5 → coef_out=0xBEEF; num_samples=0x0040.
3. Write CTRL=0x3 in IDLE → start=1 for one cycle; 0x22 reads 1. Pulse core_done → 0x21 reads 1, 0x22 reads 0. With FIR_REG_BANK_IRQ_EN defined, irq=1 one cycle later.
4. In RUN, write COEF[0]=0x1234 and CTRL=0x1 → COEF[0] unchanged, no start pulse, ERRCNT=2. Write 0x24 → ERRCNT=0.
5. Perform 300 blocked writes in RUN → ERRCNT=255 (saturated). Same cycle core_done + START write → state DONE, no start, ERRCNT stays 255.
6. Assert PRESETn=0 mid-RUN → start=0, irq=0, COEF/NSAMP=0, 0x21 and 0x22 read 0 after release.
